// File: rtl/decodificador_reg_if.sv
// ---------------------------------------------------------------------------
// decodificador_reg_if
// Bundles the control inputs and decoded outputs of the registered
// decoder so that the design and its environment share one port.
//   en        : block enable, 0 forces the decoder idle
//   modo      : 0 = direct decode, 1 = auto-scan
//   in_valid  : strobe qualifying chave in direct mode
//   chave     : select (direct) / start index (scan entry), N bits
//   saida     : registered one-hot decode, M = 2**N bits
//   out_valid : one-cycle pulse on each saida update
//   idx       : index currently driven on saida
// Modports: master drives the controls, slave is the decoder.
// ---------------------------------------------------------------------------
interface decodificador_reg_if #(
  parameter int N = 3
);
  localparam int M = 2 ** N;

  logic         en;
  logic         modo;
  logic         in_valid;
  logic [N-1:0] chave;
  logic [M-1:0] saida;
  logic         out_valid;
  logic [N-1:0] idx;

  modport master (
    output en, modo, in_valid, chave,
    input  saida, out_valid, idx
  );

  modport slave (
    input  en, modo, in_valid, chave,
    output saida, out_valid, idx
  );
endinterface

// File: rtl/decodificador_reg.sv
// ---------------------------------------------------------------------------
// decodificador_reg
// Registered N-to-2**N one-hot decoder with an optional auto-scan mode.
// In direct mode each in_valid strobe latches chave and drives 1<<chave.
// In scan mode the active line starts at chave and advances by one every
// PERIODO cycles, wrapping from the MSB back to the LSB.
//
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : decodificador_reg_if slave (en, modo, in_valid, chave,
//           saida, out_valid, idx)
// Parameters:
//   N       : select width, 1..6 (output width M = 2**N)
//   PERIODO : scan dwell in cycles per output line, 1..255
// Build option:
//   DECODIFICADOR_SCAN_EN : when defined, the SCAN state, its prescaler and
//   the PERIODO dwell are compiled in. When undefined, modo is ignored and
//   an enabled decoder always works in direct mode.
// ---------------------------------------------------------------------------
module decodificador_reg #(
  parameter int N       = 3,
  parameter int PERIODO = 4
) (
  input logic               clk,
  input logic               rst_n,
  decodificador_reg_if.slave bus
);

  localparam int M = 2 ** N;
  localparam logic [M-1:0] LsbOne = M'(1);

  // Catch illegal parameter choices at elaboration rather than in silicon.
  if (N < 1 || N > 6) begin : gBadN
    $error("decodificador_reg: N must be within 1..6");
  end
  if (PERIODO < 1 || PERIODO > 255) begin : gBadPeriodo
    $error("decodificador_reg: PERIODO must be within 1..255");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [M-1:0] saida_q, saida_d;
  logic [N-1:0] idx_q, idx_d;
  logic         outValid_q, outValid_d;
  logic         wantScan;

`ifdef DECODIFICADOR_SCAN_EN
  localparam logic [7:0] LastTick = 8'(PERIODO - 1);
  logic [7:0] prescaler_q, prescaler_d;

  // Scan is requested whenever the block is enabled with modo high.
  assign wantScan = bus.modo;
`else
  // Without the scan feature modo has no meaning; the decoder stays direct.
  assign wantScan = 1'b0;
`endif

  // State and output registers. Reset clears everything immediately,
  // which also throws away any scan or update that was in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      saida_q    <= '0;
      idx_q      <= '0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      saida_q    <= saida_d;
      idx_q      <= idx_d;
      outValid_q <= outValid_d;
    end
  end

`ifdef DECODIFICADOR_SCAN_EN
  // Dwell counter for scan mode; it only matters while in SCAN and is
  // restarted on every scan entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q <= '0;
    end else begin
      prescaler_q <= prescaler_d;
    end
  end
`endif

  // Next-state and next-output logic. Everything holds by default and
  // out_valid only pulses when a new one-hot value is loaded. Dropping en
  // wins over every other input and returns the decoder to an all-zero idle.
  // Entering SCAN from any enabled state loads chave straight away; leaving
  // SCAN for DIRECT keeps the last scanned line on the outputs.
  always_comb begin
    state_d    = state_q;
    saida_d    = saida_q;
    idx_d      = idx_q;
    outValid_d = 1'b0;
`ifdef DECODIFICADOR_SCAN_EN
    prescaler_d = prescaler_q;
`endif

    if (!bus.en) begin
      state_d = IDLE;
      saida_d = '0;
      idx_d   = '0;
`ifdef DECODIFICADOR_SCAN_EN
      prescaler_d = '0;
`endif
    end else if (wantScan && state_q != SCAN) begin
      state_d    = SCAN;
      idx_d      = bus.chave;
      saida_d    = LsbOne << bus.chave;
      outValid_d = 1'b1;
`ifdef DECODIFICADOR_SCAN_EN
      prescaler_d = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          // Entering direct mode shows nothing until the first strobe.
          state_d = DIRECT;
        end
        DIRECT: begin
          if (bus.in_valid) begin
            idx_d      = bus.chave;
            saida_d    = LsbOne << bus.chave;
            outValid_d = 1'b1;
          end
        end
        SCAN: begin
`ifdef DECODIFICADOR_SCAN_EN
          if (!wantScan) begin
            state_d = DIRECT;
          end else if (prescaler_q == LastTick) begin
            // idx is exactly N bits, so incrementing past M-1 wraps to 0.
            idx_d       = idx_q + N'(1);
            saida_d     = LsbOne << (idx_q + N'(1));
            outValid_d  = 1'b1;
            prescaler_d = '0;
          end else begin
            prescaler_d = prescaler_q + 8'd1;
          end
`else
          state_d = DIRECT;
`endif
        end
        default: begin
          state_d = IDLE;
          saida_d = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  assign bus.saida     = saida_q;
  assign bus.idx       = idx_q;
  assign bus.out_valid = outValid_q;

endmodule
